// File: rtl/vga_sync.sv
// VGA timing generator: pixel-rate divider, h/v counters, sync pulses and colour blanking.
// Define VGA_SYNC_OUT_REG_EN to register hsync/vsync/rgb one pixel behind x/y.
module vga_sync #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int TICK_DIV  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] rgb_in,
    output logic        p_tick,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        video_on,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_STOP  = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_STOP  = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div;
    logic             tick_next;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    logic             hsync_int;
    logic             vsync_int;

    // The edge that samples the last divider phase is the one that advances the counters.
    assign tick_next = (div == DIV_LAST);

    always_comb begin
        x_next = x;
        y_next = y;
        if (tick_next) begin
            if (x == X_LAST) begin
                x_next = '0;
                if (y == Y_LAST) begin
                    y_next = '0;
                end else begin
                    y_next = y + 10'd1;
                end
            end else begin
                x_next = x + 10'd1;
            end
        end
    end

    // Sync, video_on and frame_start are decoded from the next counter values so they
    // switch in the same clk as x/y.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div         <= '0;
            p_tick      <= 1'b0;
            x           <= '0;
            y           <= '0;
            video_on    <= 1'b1;
            frame_start <= 1'b0;
            hsync_int   <= 1'b1;
            vsync_int   <= 1'b1;
        end else begin
            div         <= tick_next ? '0 : div + DIV_ONE;
            p_tick      <= tick_next;
            x           <= x_next;
            y           <= y_next;
            video_on    <= (x_next < X_VIS) && (y_next < Y_VIS);
            frame_start <= tick_next && (x_next == 10'd0) && (y_next == 10'd0);
            hsync_int   <= !((x_next >= HS_START) && (x_next < HS_STOP));
            vsync_int   <= !((y_next >= VS_START) && (y_next < VS_STOP));
        end
    end

`ifdef VGA_SYNC_OUT_REG_EN
    logic        hsync_q;
    logic        vsync_q;
    logic [11:0] rgb_q;

    // Loaded on the pixel-advance edge, so the pins carry the pixel that x/y just left.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 12'h000;
        end else if (tick_next) begin
            hsync_q <= hsync_int;
            vsync_q <= vsync_int;
            rgb_q   <= video_on ? rgb_in : 12'h000;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign rgb   = rgb_q;
`else
    assign hsync = hsync_int;
    assign vsync = vsync_int;
    // video_on resets high, so reset_n also gates the pins to keep them dark in reset.
    assign rgb   = (video_on && reset_n) ? rgb_in : 12'h000;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: default-timing instance plus a shrunken-timing instance so whole
// frames fit in a short run; both are compared every clk against a position-from-clk-count model.
`timescale 1ns/1ps
module tb_vga_sync;

    localparam int A_HD = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VD = 480, A_VF = 10, A_VS = 2,  A_VB = 33, A_TD = 4;
    localparam int B_HD = 8,   B_HF = 2,  B_HS = 3,  B_HB = 2;
    localparam int B_VD = 5,   B_VF = 2,  B_VS = 2,  B_VB = 1,  B_TD = 3;
    localparam int B_FRAME  = (B_HD + B_HF + B_HS + B_HB) * (B_VD + B_VF + B_VS + B_VB) * B_TD;
    localparam int N_STEPS  = 4000;
    localparam int B_RST_AT = 1252;  // x=12, y=7: inside both sync pulses of the small timing

    typedef struct packed {
        logic        p_tick;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        video_on;
        logic        frame_start;
        logic        hsync;
        logic        vsync;
        logic [11:0] rgb;
    } pins_t;

    // clock / reset
    logic clk = 1'b0;
    logic reset_n_a = 1'b0;
    logic reset_n_b = 1'b0;
    logic [11:0] rgb_in = 12'h000;
    always #5 clk = ~clk;

    logic        p_tick_a, video_on_a, frame_start_a, hsync_a, vsync_a;
    logic [9:0]  x_a, y_a;
    logic [11:0] rgb_a;
    logic        p_tick_b, video_on_b, frame_start_b, hsync_b, vsync_b;
    logic [9:0]  x_b, y_b;
    logic [11:0] rgb_b;

    vga_sync dut_a (
        .clk(clk), .reset_n(reset_n_a), .rgb_in(rgb_in),
        .p_tick(p_tick_a), .x(x_a), .y(y_a), .video_on(video_on_a),
        .frame_start(frame_start_a), .hsync(hsync_a), .vsync(vsync_a), .rgb(rgb_a)
    );

    vga_sync #(
        .H_DISPLAY(B_HD), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_DISPLAY(B_VD), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB), .TICK_DIV(B_TD)
    ) dut_b (
        .clk(clk), .reset_n(reset_n_b), .rgb_in(rgb_in),
        .p_tick(p_tick_b), .x(x_b), .y(y_b), .video_on(video_on_b),
        .frame_start(frame_start_b), .hsync(hsync_b), .vsync(vsync_b), .rgb(rgb_b)
    );

    int checks = 0;
    int errors = 0;
    int ka = 0;
    int kb = 0;
    logic [11:0] tick_rgb_a = 12'h000;
    logic [11:0] tick_rgb_b = 12'h000;
    int hs_low_a = 0;
    int fs_cnt_b = 0;
    int last_fs_b = 0;
    logic b_rst_done = 1'b0;

    // reference model: k = clk edges since reset release (0 = held/just reset)
    function automatic pins_t model(input int k, input int hd, input int hf, input int hs,
                                    input int hb, input int vd, input int vf, input int vs,
                                    input int vb, input int td,
                                    input logic [11:0] rin_now, input logic [11:0] rin_tick);
        pins_t e;
        int ht, vt, p, px, py, q, qx, qy;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        e = '{p_tick: 1'b0, x: 10'd0, y: 10'd0, video_on: 1'b1, frame_start: 1'b0,
              hsync: 1'b1, vsync: 1'b1, rgb: 12'h000};
        if (k == 0) return e;
        p  = k / td;
        px = p % ht;
        py = (p / ht) % vt;
        e.p_tick      = (k % td == 0);
        e.x           = 10'(px);
        e.y           = 10'(py);
        e.video_on    = (px < hd) && (py < vd);
        e.frame_start = e.p_tick && (p % (ht * vt) == 0);
`ifdef VGA_SYNC_OUT_REG_EN
        if (p > 0) begin
            q  = p - 1;
            qx = q % ht;
            qy = (q / ht) % vt;
            e.hsync = !((qx >= hd + hf) && (qx < hd + hf + hs));
            e.vsync = !((qy >= vd + vf) && (qy < vd + vf + vs));
            e.rgb   = ((qx < hd) && (qy < vd)) ? rin_tick : 12'h000;
        end
`else
        q = 0; qx = 0; qy = 0;
        e.hsync = !((px >= hd + hf) && (px < hd + hf + hs));
        e.vsync = !((py >= vd + vf) && (py < vd + vf + vs));
        e.rgb   = e.video_on ? rin_now : 12'h000;
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pins(input string nm, input pins_t o, input pins_t e);
        chk({nm, ".p_tick"},      32'(o.p_tick),      32'(e.p_tick));
        chk({nm, ".x"},           32'(o.x),           32'(e.x));
        chk({nm, ".y"},           32'(o.y),           32'(e.y));
        chk({nm, ".video_on"},    32'(o.video_on),    32'(e.video_on));
        chk({nm, ".frame_start"}, 32'(o.frame_start), 32'(e.frame_start));
        chk({nm, ".hsync"},       32'(o.hsync),       32'(e.hsync));
        chk({nm, ".vsync"},       32'(o.vsync),       32'(e.vsync));
    endtask

    // driver: one clk; registered outputs checked #1 after the edge, then rgb_in is
    // changed and the colour pins are checked again
    task automatic step(input logic [11:0] rin_next);
        pins_t ea, eb, oa, ob;
        @(posedge clk);
        if (reset_n_a) begin
            if ((ka + 1) % A_TD == 0) tick_rgb_a = rgb_in;
            ka++;
        end else begin
            ka = 0;
        end
        if (reset_n_b) begin
            if ((kb + 1) % B_TD == 0) tick_rgb_b = rgb_in;
            kb++;
        end else begin
            kb = 0;
            last_fs_b = 0;
        end
        #1;
        ea = model(ka, A_HD, A_HF, A_HS, A_HB, A_VD, A_VF, A_VS, A_VB, A_TD, rgb_in, tick_rgb_a);
        eb = model(kb, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB, B_TD, rgb_in, tick_rgb_b);
        oa = '{p_tick_a, x_a, y_a, video_on_a, frame_start_a, hsync_a, vsync_a, rgb_a};
        ob = '{p_tick_b, x_b, y_b, video_on_b, frame_start_b, hsync_b, vsync_b, rgb_b};
        check_pins("a", oa, ea);
        check_pins("b", ob, eb);
        if (ka >= 1 && ka <= A_TD * (A_HD + A_HF + A_HS + A_HB) && !hsync_a) hs_low_a++;
        if (frame_start_b) begin
            fs_cnt_b++;
            if (last_fs_b > 0) chk("b.fs_period", 32'(kb - last_fs_b), 32'(B_FRAME));
            last_fs_b = kb;
        end
        rgb_in = rin_next;
        #1;
        ea = model(ka, A_HD, A_HF, A_HS, A_HB, A_VD, A_VF, A_VS, A_VB, A_TD, rgb_in, tick_rgb_a);
        eb = model(kb, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB, B_TD, rgb_in, tick_rgb_b);
        chk("a.rgb", 32'(rgb_a), 32'(ea.rgb));
        chk("b.rgb", 32'(rgb_b), 32'(eb.rgb));
    endtask

    initial begin
        logic [11:0] rin;
        // reset held for a few clks with random colour on the input
        reset_n_a = 1'b0;
        reset_n_b = 1'b0;
        rgb_in = 12'(($urandom));
        repeat (3) step(12'($urandom));

        reset_n_a = 1'b1;
        reset_n_b = 1'b1;
        for (int i = 0; i < N_STEPS; i++) begin
            if (i < 1200)      rin = 12'h0F0;
            else if (i < 3300) rin = 12'hFFF;
            else               rin = 12'($urandom_range(0, 4095));
            step(rin);
            // single-clk reset of the small instance mid-line, mid-vsync
            if (!reset_n_b) begin
                reset_n_b = 1'b1;
            end else if (!b_rst_done && kb == B_RST_AT) begin
                reset_n_b  = 1'b0;
                b_rst_done = 1'b1;
            end
        end

        chk("a.hsync_low_clks", 32'(hs_low_a), 32'(A_HS * A_TD));
        chk("b.frame_start_cnt", 32'(fs_cnt_b),
            32'(B_RST_AT / B_FRAME + (N_STEPS - 1 - B_RST_AT) / B_FRAME));
        chk("b.reset_applied", 32'(b_rst_done), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync.md
# vga_sync

Timing generator and pixel output stage for the VGA port. Divides the system clock down to the pixel rate, runs the horizontal and vertical counters, and produces `hsync`, `vsync`, `video_on` and the pixel coordinates consumed by the object generators and `color_mux`. It takes back the 12-bit colour from `color_mux`, blanks it outside the visible area, and drives the `rgb` pins. It is the endpoint of the colour path.

## Interface
- `H_DISPLAY`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: hsync pulse width (pixels)
- `H_BACK`, 48: horizontal back porch (pixels)
- `V_DISPLAY`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vsync pulse width (lines)
- `V_BACK`, 33: vertical back porch (lines)
- `TICK_DIV`, 4: clk cycles per pixel (100 MHz -> 25 MHz)
- `clk`  in  1  system clock, 100 MHz
- `reset_n`  in  1  synchronous, active-low reset
- `rgb_in`  in  12  colour from `color_mux`, {R[3:0],G[3:0],B[3:0]}
- `p_tick`  out  1  one-clk pulse, once every `TICK_DIV` clks
- `x`  out  10  horizontal count, 0..H_TOTAL-1
- `y`  out  10  vertical count, 0..V_TOTAL-1
- `video_on`  out  1  high when x < H_DISPLAY and y < V_DISPLAY
- `frame_start`  out  1  one-clk pulse when the counters enter (0,0)
- `hsync`  out  1  horizontal sync pin, active low
- `vsync`  out  1  vertical sync pin, active low
- `rgb`  out  12  colour pins

## Operation
- H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525).
- Divider counter `div` runs 0..TICK_DIV-1 and wraps. `p_tick` is registered and is high during the clk after `div` == TICK_DIV-1.
- On each `p_tick`:
  - `x` increments.
  - When `x` == H_TOTAL-1, `x` wraps to 0 and `y` increments.
  - When `y` == V_TOTAL-1 at the same time, `y` also wraps to 0.
- `hsync` and `vsync` are registered. They are computed from the next counter values, so they change in the same clk as `x` and `y`.
  - `hsync` = 0 when H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - `vsync` = 0 when V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC (490..491).
- `video_on` is registered the same way and is always consistent with the current `x`/`y`.
- `frame_start` is high for exactly the one clk in which `x`,`y` first read (0,0) after a wrap. It is not asserted out of reset.
- Colour path: when `video_on` = 0, `rgb` = 12'h000 regardless of `rgb_in`.
- Reset (`reset_n` = 0 at a clk edge), from any state including mid-line or mid-frame:
  - `div` = 0, `x` = 0, `y` = 0
  - `p_tick` = 0, `frame_start` = 0
  - `hsync` = 1, `vsync` = 1
  - `video_on` = 1
  - `rgb` = 12'h000
- Counter widths are 10 bits, so H_TOTAL and V_TOTAL must be <= 1024. Counter arithmetic is unsigned and never exceeds TOTAL-1.

## Timing
- First `p_tick` comes TICK_DIV clks after `reset_n` is released (clk TICK_DIV, counting the first non-reset edge as clk 1).
- `x`/`y` update in the clk following the edge that samples `div` == TICK_DIV-1. This is the same clk in which `p_tick` is high.
- Each pixel position is held for exactly TICK_DIV clks. A line is 3200 clks. A frame is 1,680,000 clks.
- `frame_start` period is exactly H_TOTAL*V_TOTAL*TICK_DIV clks.
- Without the output register, `rgb` is combinational from `rgb_in` and `video_on`, with zero latency relative to `x`/`y`.

## Configuration
- `VGA_SYNC_OUT_REG_EN` defined:
  - `hsync`, `vsync` and `rgb` pass through one extra register stage, loaded on `p_tick`.
  - Pins lag `x`/`y` by exactly one pixel, which absorbs the object-generator and `color_mux` combinational delay.
  - `rgb` captures `rgb_in`, blanked with the `video_on` value of the previous pixel.
  - Reset values are unchanged: 1, 1, 12'h000.
- Undefined:
  - Pins are aligned with `x`/`y` as described above.
  - `rgb` is combinational.

## Test plan
- Reset release -> `p_tick` first high at clk 4 and every 4 clks thereafter. `x` reads 1 after the first tick. `hsync` = `vsync` = 1 and `rgb` = 0 during reset.
- Run one line with `rgb_in` = 12'hFFF -> `hsync` low for exactly 96 ticks starting at x = 656. `video_on` high for x 0..639. `rgb` = 12'h000 for x >= 640. `x` wraps 799 -> 0 and `y` 0 -> 1.
- Run one full frame -> `vsync` low only for y = 490..491 (1600 ticks). `frame_start` pulses once, 1,680,000 clks after the previous pulse. `y` wraps 524 -> 0.
- Assert `reset_n` = 0 for one clk at x = 700, y = 491 -> next clk shows `x` = 0, `y` = 0, `hsync` = `vsync` = 1, `p_tick` = 0, and no `frame_start`.
- Hold `rgb_in` = 12'h0F0 with `VGA_SYNC_OUT_REG_EN` defined -> `rgb` = 12'h0F0 first appears when `x` = 1, y = 0. `rgb` = 12'h000 from x = 641 to x = 0 of the next line. `hsync` falls when `x` = 657.
